// File: rtl/imem_loader.sv
// imem_loader: boot loader turning a framed UART byte stream into 32-bit instruction memory writes.
// Build option IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
module imem_loader #(
  parameter int MEM_WORDS = 8196,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_PAY_END = S_CSUM;
`else
  localparam logic [2:0] S_PAY_END = S_DONE;
`endif

  logic [2:0]        state_r;
  logic [2:0]        state_nx_s;
  logic [1:0]        byte_cnt_r;
  logic [31:0]       len_r;
  logic [23:0]       word_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic [31:0]       len_full_s;
  logic [31:0]       word_full_s;
  logic              accept_s;
  logic              sync_s;
  logic              last_word_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_r;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Length and payload arrive little-endian, so new bytes shift in from the top.
  assign accept_s    = rx_valid & rx_ready;
  assign sync_s      = (rx_data == 8'hA5);
  assign len_full_s  = {rx_data, len_r[31:8]};
  assign word_full_s = {rx_data, word_r};
  assign last_word_s = ({{(32-ADDR_W){1'b0}}, word_idx_r} == (len_r - 32'd1));

  // Next-state decode; the state only moves on an accepted byte.
  always_comb begin
    state_nx_s = state_r;
    if (accept_s) begin
      case (state_r)
        S_IDLE, S_DONE, S_ERROR: begin
          if (sync_s) state_nx_s = S_LEN;
          else        state_nx_s = state_r;
        end
        S_LEN: begin
          if (byte_cnt_r != 2'd3)                 state_nx_s = state_r;
          else if (len_full_s > 32'(MEM_WORDS))   state_nx_s = S_ERROR;
          else if (len_full_s == 32'd0)           state_nx_s = S_PAY_END;
          else                                    state_nx_s = S_DATA;
        end
        S_DATA: begin
          if ((byte_cnt_r == 2'd3) && last_word_s) state_nx_s = S_PAY_END;
          else                                     state_nx_s = state_r;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_data == xor_r) state_nx_s = S_DONE;
          else                  state_nx_s = S_ERROR;
        end
`endif
        default: state_nx_s = S_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Frame datapath, memory write port and status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      byte_cnt_r <= 2'd0;
      len_r      <= 32'd0;
      word_r     <= 24'd0;
      word_idx_r <= {ADDR_W{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_r      <= 8'd0;
`endif
      rx_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      rx_ready   <= 1'b1;
      mem_we     <= 1'b0;
      cpu_hold   <= (state_nx_s != S_DONE);
      load_done  <= (state_nx_s == S_DONE);
      load_error <= (state_nx_s == S_ERROR);
      if (accept_s) begin
        case (state_r)
          S_IDLE, S_DONE, S_ERROR: begin
            if (sync_s) begin
              byte_cnt_r <= 2'd0;
              len_r      <= 32'd0;
              word_r     <= 24'd0;
              word_idx_r <= {ADDR_W{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
              xor_r      <= 8'd0;
`endif
            end
          end
          S_LEN: begin
            len_r      <= len_full_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
          end
          S_DATA: begin
            word_r     <= word_full_s[31:8];
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r      <= xor_fold(xor_r, rx_data);
`endif
            if (byte_cnt_r == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= {{(30-ADDR_W){1'b0}}, word_idx_r, 2'b00};
              mem_wdata <= word_full_s;
              // Hold the index on the final word so it never reaches MEM_WORDS.
              if (!last_word_s) word_idx_r <= word_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized frames checked against expectations built from frame contents.
module tb_imem_loader;
  localparam int MEM_WORDS = 8196;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_we = -100;
  int spacing_err = 0;
  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];
  logic [31:0] pay_q[$];

  always #5 clk = ~clk;

  imem_loader #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  // Write monitor: records every write and the spacing between strobes.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we === 1'b1 && rst === 1'b0) begin
      if (cyc - last_we < 4) spacing_err <= spacing_err + 1;
      last_we <= cyc;
      got_addr_q.push_back(mem_addr);
      got_data_q.push_back(mem_wdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic apply_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    rst = 1'b0;
    got_addr_q.delete();
    got_data_q.delete();
  endtask

  // Sends sync, length, every word of pay_q and (when built) the correct XOR byte.
  task automatic send_frame(input logic [31:0] len, input int gap);
    logic [7:0] b;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    send_byte(8'hA5, gap);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gap);
    for (int w = 0; w < pay_q.size(); w++) begin
      for (int k = 0; k < 4; k++) begin
        b = pay_q[w][8*k +: 8];
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = x ^ b;
`endif
        send_byte(b, gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x, gap);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    n_tests += 7;
    if (rx_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_rx_ready got %0h want 1", rx_ready); end
    if (mem_we !== 1'b0)      begin n_fail++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
    if (mem_addr !== 32'd0)   begin n_fail++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
    if (mem_wdata !== 32'd0)  begin n_fail++; $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata); end
    if (cpu_hold !== 1'b1)    begin n_fail++; $display("FAIL reset_cpu_hold got %0h want 1", cpu_hold); end
    if (load_done !== 1'b0)   begin n_fail++; $display("FAIL reset_load_done got %0h want 0", load_done); end
    if (load_error !== 1'b0)  begin n_fail++; $display("FAIL reset_load_error got %0h want 0", load_error); end
    rst = 1'b0;
  endtask

  task automatic test_basic(input int gap);
    apply_reset;
    pay_q = '{32'h12345678, 32'hDEADBEEF};
    send_frame(32'd2, gap);
    n_tests += 3;
    if (load_done !== 1'b1)  begin n_fail++; $display("FAIL basic_done gap=%0d got %0h want 1", gap, load_done); end
    if (cpu_hold !== 1'b0)   begin n_fail++; $display("FAIL basic_hold gap=%0d got %0h want 0", gap, cpu_hold); end
    if (load_error !== 1'b0) begin n_fail++; $display("FAIL basic_error gap=%0d got %0h want 0", gap, load_error); end
    idle(1);
    n_tests++;
    if (got_addr_q.size() !== 2) begin n_fail++; $display("FAIL basic_count gap=%0d got %0d want 2", gap, got_addr_q.size()); end
    for (int i = 0; i < 2 && i < got_addr_q.size(); i++) begin
      n_tests += 2;
      if (got_addr_q[i] !== 32'(4*i)) begin n_fail++; $display("FAIL basic_addr%0d got %0h want %0h", i, got_addr_q[i], 4*i); end
      if (got_data_q[i] !== pay_q[i]) begin n_fail++; $display("FAIL basic_data%0d got %0h want %0h", i, got_data_q[i], pay_q[i]); end
    end
  endtask

  task automatic test_restart;
    // Continues from the DONE left by test_basic(3).
    send_byte(8'hA5, 3);
    n_tests += 2;
    if (cpu_hold !== 1'b1)  begin n_fail++; $display("FAIL restart_hold got %0h want 1", cpu_hold); end
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL restart_done got %0h want 0", load_done); end
  endtask

  task automatic test_garbage;
    apply_reset;
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    idle(2);
    n_tests += 2;
    if (got_addr_q.size() !== 0) begin n_fail++; $display("FAIL garbage_nowrite got %0d want 0", got_addr_q.size()); end
    if (cpu_hold !== 1'b1)       begin n_fail++; $display("FAIL garbage_hold got %0h want 1", cpu_hold); end
    pay_q = '{$urandom()};
    send_frame(32'd1, 0);
    idle(1);
    n_tests += 2;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL garbage_done got %0h want 1", load_done); end
    if (got_addr_q.size() !== 1 || got_addr_q[0] !== 32'd0 || got_data_q[0] !== pay_q[0]) begin
      n_fail++; $display("FAIL garbage_write n=%0d want 1 word %0h at 0", got_addr_q.size(), pay_q[0]);
    end
  endtask

  task automatic test_length_bounds;
    apply_reset;
    send_byte(8'hA5, 0); send_byte(8'h05, 0); send_byte(8'h20, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    n_tests += 3;
    if (load_error !== 1'b1) begin n_fail++; $display("FAIL oversize_error got %0h want 1", load_error); end
    if (cpu_hold !== 1'b1)   begin n_fail++; $display("FAIL oversize_hold got %0h want 1", cpu_hold); end
    if (load_done !== 1'b0)  begin n_fail++; $display("FAIL oversize_done got %0h want 0", load_done); end
    idle(3);
    n_tests++;
    if (got_addr_q.size() !== 0) begin n_fail++; $display("FAIL oversize_nowrite got %0d want 0", got_addr_q.size()); end
    // Zero-length image restarts from ERROR and completes without writes.
    pay_q.delete();
    send_frame(32'd0, 0);
    idle(1);
    n_tests += 3;
    if (load_done !== 1'b1)      begin n_fail++; $display("FAIL zero_len_done got %0h want 1", load_done); end
    if (load_error !== 1'b0)     begin n_fail++; $display("FAIL zero_len_error got %0h want 0", load_error); end
    if (got_addr_q.size() !== 0) begin n_fail++; $display("FAIL zero_len_nowrite got %0d want 0", got_addr_q.size()); end
    // Exactly MEM_WORDS is a legal length.
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h20, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    n_tests += 2;
    if (load_error !== 1'b0) begin n_fail++; $display("FAIL maxlen_error got %0h want 0", load_error); end
    if (cpu_hold !== 1'b1)   begin n_fail++; $display("FAIL maxlen_hold got %0h want 1", cpu_hold); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] hdr [0:8];
    hdr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    apply_reset;
    for (int i = 0; i < 9; i++) send_byte(hdr[i], 0);
    send_byte(8'h05, 0);
    n_tests += 3;
    if (load_error !== 1'b1) begin n_fail++; $display("FAIL csum_bad_error got %0h want 1", load_error); end
    if (cpu_hold !== 1'b1)   begin n_fail++; $display("FAIL csum_bad_hold got %0h want 1", cpu_hold); end
    if (load_done !== 1'b0)  begin n_fail++; $display("FAIL csum_bad_done got %0h want 0", load_done); end
    for (int i = 0; i < 9; i++) send_byte(hdr[i], 0);
    send_byte(8'h04, 0);
    n_tests += 2;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL csum_good_done got %0h want 1", load_done); end
    if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL csum_good_hold got %0h want 0", cpu_hold); end
    idle(1);
    n_tests++;
    if (got_data_q.size() !== 2 || got_data_q[1] !== 32'h04030201) begin
      n_fail++; $display("FAIL csum_writes n=%0d want 2 words of 04030201", got_data_q.size());
    end
  endtask
`endif

  task automatic test_reset_midframe;
    apply_reset;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests += 2;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_status hold=%0h done=%0h want 1/0", cpu_hold, load_done);
    end
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %0h want 0", mem_we); end
    got_addr_q.delete(); got_data_q.delete();
    pay_q = '{32'hCAFEF00D};
    send_frame(32'd1, 0);
    idle(1);
    n_tests += 2;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL midrst_done got %0h want 1", load_done); end
    if (got_addr_q.size() !== 1 || got_addr_q[0] !== 32'd0 || got_data_q[0] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL midrst_write n=%0d want one word cafef00d at 0", got_addr_q.size());
    end
  endtask

  task automatic test_random_frames;
    int n;
    int gap;
    apply_reset;
    for (int it = 0; it < 8; it++) begin
      n   = int'($urandom_range(1, 6));
      gap = int'($urandom_range(0, 2));
      pay_q.delete();
      for (int w = 0; w < n; w++) pay_q.push_back($urandom());
      got_addr_q.delete(); got_data_q.delete();
      send_frame(32'(n), gap);
      idle(1);
      n_tests += 2;
      if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_status done=%0h hold=%0h want 1/0", it, load_done, cpu_hold);
      end
      if (got_addr_q.size() !== n) begin n_fail++; $display("FAIL rand%0d_count got %0d want %0d", it, got_addr_q.size(), n); end
      for (int w = 0; w < n && w < got_addr_q.size(); w++) begin
        n_tests++;
        if (got_addr_q[w] !== 32'(4*w) || got_data_q[w] !== pay_q[w]) begin
          n_fail++; $display("FAIL rand%0d_word%0d got %0h@%0h want %0h@%0h", it, w, got_data_q[w], got_addr_q[w], pay_q[w], 4*w);
        end
      end
    end
    n_tests++;
    if (spacing_err !== 0) begin n_fail++; $display("FAIL we_spacing got %0d violations want 0", spacing_err); end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    test_reset;
    test_basic(0);
    test_basic(3);
    test_restart;
    test_garbage;
    test_length_bounds;
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    test_reset_midframe;
    test_random_frames;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
